// File: rtl/six_code_pkg.sv
// Shared constants for the six-state cyclic code tracker.
package six_code_pkg;

    // Upstream code sequence in phase order; the carry accompanies CODE5.
    localparam logic [2:0] CODE0 = 3'b010;
    localparam logic [2:0] CODE1 = 3'b011;
    localparam logic [2:0] CODE2 = 3'b111;
    localparam logic [2:0] CODE3 = 3'b110;
    localparam logic [2:0] CODE4 = 3'b100;
    localparam logic [2:0] CODE5 = 3'b000;

    // Phase index reported for the two codes the counter never emits.
    localparam logic [2:0] IDX_ILLEGAL = 3'd7;

    // Sticky error flags grouped so they can be cleared and updated together.
    typedef struct packed {
        logic illegal_err;
        logic seq_err;
        logic carry_err;
    } err_flags_t;

endpackage

// File: rtl/six_code_decode.sv
// Combinational decode of one upstream code: phase index, legality and successor.
module six_code_decode
    import six_code_pkg::*;
(
    input  logic [2:0] code,
    output logic [2:0] idx,
    output logic       legal,
    output logic [2:0] next_code
);

    // Map each code to its phase, flag the two illegal codes and give the expected successor.
    always_comb begin
        idx       = IDX_ILLEGAL;
        legal     = 1'b0;
        next_code = CODE0;
        case (code)
            CODE0: begin
                idx       = 3'd0;
                legal     = 1'b1;
                next_code = CODE1;
            end
            CODE1: begin
                idx       = 3'd1;
                legal     = 1'b1;
                next_code = CODE2;
            end
            CODE2: begin
                idx       = 3'd2;
                legal     = 1'b1;
                next_code = CODE3;
            end
            CODE3: begin
                idx       = 3'd3;
                legal     = 1'b1;
                next_code = CODE4;
            end
            CODE4: begin
                idx       = 3'd4;
                legal     = 1'b1;
                next_code = CODE5;
            end
            CODE5: begin
                idx       = 3'd5;
                legal     = 1'b1;
                next_code = CODE0;
            end
            default: begin
                // 001 / 101: no successor exists, the stream re-synchronises on the next sample.
                idx       = IDX_ILLEGAL;
                legal     = 1'b0;
                next_code = CODE0;
            end
        endcase
    end

endmodule

// File: rtl/six_code_tracker.sv
// Tracks the 6-state cyclic counter: registers the phase, counts carries into a
// wider cycle counter and latches sticky errors for illegal codes, out-of-order
// transitions and carry/code mismatches.
module six_code_tracker
    import six_code_pkg::*;
#(
    parameter int CYC_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       q_in,
    input  logic             c_in,
    input  logic             clr,
    output logic             valid,
    output logic [2:0]       idx,
    output logic [CYC_W-1:0] cycles,
    output logic             tc,
    output logic             illegal_err,
    output logic             seq_err,
    output logic             carry_err
);

    // Decode of the code currently on the input.
    logic [2:0]       cur_idx_s;
    logic             cur_legal_s;
    logic [2:0]       cur_next_s;

    // Registered state. The previous code is kept in decoded form (its
    // successor and legality), which is all the sequence check needs.
    logic             valid_r;
    logic [2:0]       idx_r;
    logic [CYC_W-1:0] cycles_r;
    logic             tc_r;
    err_flags_t       err_r;
    logic             primed_r;
    logic [2:0]       prev_next_r;
    logic             prev_legal_r;

    // Next-state values for the counter and error flags.
    logic [CYC_W-1:0] cycles_nxt_s;
    logic             tc_nxt_s;
    err_flags_t       hit_s;
    err_flags_t       err_nxt_s;

    six_code_decode u_decode (
        .code      (q_in),
        .idx       (cur_idx_s),
        .legal     (cur_legal_s),
        .next_code (cur_next_s)
    );

    // Detect this sample's error conditions and form the next counter/flag values; clr wins.
    always_comb begin
        hit_s.illegal_err = ~cur_legal_s;
        hit_s.carry_err   = c_in ^ (q_in == CODE5);
        if (primed_r && prev_legal_r) begin
            hit_s.seq_err = (q_in != prev_next_r);
        end else begin
            hit_s.seq_err = 1'b0;
        end

        cycles_nxt_s = cycles_r;
        tc_nxt_s     = 1'b0;
        err_nxt_s    = err_r;
        if (clr) begin
            cycles_nxt_s = {CYC_W{1'b0}};
            tc_nxt_s     = 1'b0;
            err_nxt_s    = '{illegal_err: 1'b0, seq_err: 1'b0, carry_err: 1'b0};
        end else begin
            if (c_in) begin
                cycles_nxt_s = cycles_r + {{(CYC_W-1){1'b0}}, 1'b1};
                tc_nxt_s     = &cycles_r;
            end else begin
                cycles_nxt_s = cycles_r;
                tc_nxt_s     = 1'b0;
            end
            err_nxt_s = err_r | hit_s;
        end
    end

    // Register phase tracking, cycle counter and sticky flags; reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r      <= 1'b0;
            idx_r        <= 3'd0;
            cycles_r     <= {CYC_W{1'b0}};
            tc_r         <= 1'b0;
            err_r        <= '{illegal_err: 1'b0, seq_err: 1'b0, carry_err: 1'b0};
            primed_r     <= 1'b0;
            prev_next_r  <= CODE1;
            prev_legal_r <= 1'b1;
        end else begin
            valid_r      <= 1'b1;
            idx_r        <= cur_idx_s;
            cycles_r     <= cycles_nxt_s;
            tc_r         <= tc_nxt_s;
            err_r        <= err_nxt_s;
            primed_r     <= 1'b1;
            prev_next_r  <= cur_next_s;
            prev_legal_r <= cur_legal_s;
        end
    end

    assign valid       = valid_r;
    assign idx         = idx_r;
    assign cycles      = cycles_r;
    assign tc          = tc_r;
    assign illegal_err = err_r.illegal_err;
    assign seq_err     = err_r.seq_err;
    assign carry_err   = err_r.carry_err;

endmodule
